uart_loader: RTL
================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit.
REQ-002 Parameter BASE_ADDR, default 32'h0, meaning byte address of first word written.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  loader enable; low holds loader idle.
REQ-006 rxd_pin  input  1  UART serial line, 8N1, idle high, LSB first.
REQ-007 mem_addr  output  32  bram byte address of current write.
REQ-008 mem_data  output  32  bram write data.
REQ-009 mem_write  output  1  bram write strobe, one cycle per word.
REQ-010 done  output  1  level; image fully loaded.
REQ-011 frame_err  output  1  sticky; stop bit sampled low.
REQ-012 words_left  output  16  words still to be written.

Function
REQ-013 rxd_pin SHALL pass through a 2-flop synchronizer; all RX logic SHALL use the synchronized value.
REQ-014 RX FSM states SHALL be IDLE, START, DATA, STOP, with one bit-cycle counter and a 3-bit bit index.
REQ-015 IDLE->START on synchronized line low; counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1, line low -> DATA with counter cleared; line high -> IDLE (glitch, no byte).
REQ-017 DATA: every CLKS_PER_BIT cycles, shift in one bit LSB first; after bit 7 -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, line high -> one-cycle internal byte_valid with byte; line low -> frame_err set, no byte_valid; both -> IDLE.
REQ-019 Loader FSM states SHALL be HDR0, HDR1, WORD, DONE, ERROR.
REQ-020 HDR0: byte_valid -> latch count[7:0], go HDR1; HDR1: byte_valid -> latch count[15:8], words_left = count.
REQ-021 From HDR1, count = 0 SHALL go directly to DONE; otherwise WORD with byte index 0 and word index 0.
REQ-022 WORD: bytes SHALL assemble little-endian (byte 0 -> bits 7:0).
REQ-023 On the 4th byte_valid of a word, the next cycle SHALL assert mem_write for exactly one cycle with mem_data = assembled word and mem_addr = BASE_ADDR + 4*word index (mod 2^32).
REQ-024 In the mem_write cycle words_left SHALL decrement and word index increment; words_left reaching 0 -> DONE in the same cycle.
REQ-025 DONE: done = 1; further bytes ignored; held until rst or en falling.
REQ-026 Any frame error while en=1 SHALL move the loader to ERROR; ERROR ignores bytes, done=0, exits only on rst.
REQ-027 en = 0 SHALL force loader to HDR0 (from HDR0/HDR1/WORD/DONE) next cycle, clearing done, words_left, partial word; RX FSM keeps running; bytes while en=0 discarded; ERROR unaffected.
REQ-028 Byte completing simultaneously with en falling SHALL be discarded.
REQ-029 mem_write SHALL never assert outside WORD->write cycle; mem_addr/mem_data hold last value otherwise.

Reset
REQ-030 rst SHALL take priority over all inputs, including mid-frame and mid-word.
REQ-031 After rst: RX IDLE, loader HDR0, mem_addr = BASE_ADDR, mem_data = 0, mem_write = 0, done = 0, frame_err = 0, words_left = 0, synchronizer flops = 1.

Verification (CLKS_PER_BIT = 4, BASE_ADDR = 0)
REQ-032 en=1, send 02 00 78 56 34 12 EF BE AD DE -> writes 0x12345678@0 then 0xDEADBEEF@4, one cycle each; words_left 2->1->0; done=1.
REQ-033 Send 00 00 -> done=1 after 2nd byte, no mem_write.
REQ-034 Low pulse 1 clk on idle rxd_pin -> no byte, frame_err=0, state unchanged.
REQ-035 Header 01 00, then byte 0x55 with stop bit low -> frame_err=1, loader ERROR, no mem_write; later valid bytes ignored until rst.
REQ-036 Send 01 00 AA BB, drop en for 1 cycle, raise, send 01 00 11 22 33 44 -> single write 0x44332211@0, done=1.
REQ-037 Assert rst mid-DATA of 3rd byte -> all outputs at reset values next cycle; fresh 01 00 + 4 bytes loads correctly.

Source files
------------

// File: rtl/uart_loader_if.sv
// Memory write bus from the UART loader to a BRAM port.
interface uart_loader_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;

  modport master (output mem_addr, output mem_data, output mem_write);
  modport slave  (input  mem_addr, input  mem_data, input  mem_write);
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: receives a 16-bit little-endian word count followed by
// that many little-endian 32-bit words over 8N1 serial and writes them to BRAM.
module uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                rxd_pin,
  uart_loader_if.master       mem,
  output logic                done,
  output logic                frame_err,
  output logic [15:0]         words_left
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {LD_HDR0, LD_HDR1, LD_WORD, LD_DONE, LD_ERROR} ld_state_e;

  // ---------------- receiver ----------------
  logic             sync1_q, sync2_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             ferr_pulse_q, ferr_pulse_d;
  logic             frame_err_q;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd_pin;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      ferr_pulse_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ferr_pulse_q <= ferr_pulse_d;
      frame_err_q  <= frame_err_q | ferr_pulse_d;
    end
  end

  // Receiver next state: mid-bit sampling driven by one bit-cycle counter.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    ferr_pulse_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          idx_d      = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          byte_valid_d = sync2_q;
          ferr_pulse_d = !sync2_q;
          rx_state_d   = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_e   ld_q, ld_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] words_left_q, words_left_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_write_q, mem_write_d;
  logic        done_q, done_d;

  // Loader state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q         <= LD_HDR0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      mem_addr_q   <= BASE_ADDR;
      mem_data_q   <= '0;
      mem_write_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ld_q         <= ld_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      word_idx_q   <= word_idx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_write_q  <= mem_write_d;
      done_q       <= done_d;
    end
  end

  // Loader next state: disable beats everything except ERROR, then frame errors, then bytes.
  always_comb begin
    ld_d         = ld_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    word_idx_d   = word_idx_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_write_d  = 1'b0;
    if (!en && ld_q != LD_ERROR) begin
      ld_d         = LD_HDR0;
      words_left_d = '0;
      word_idx_d   = '0;
      bidx_d       = '0;
      word_d       = '0;
    end else if (ferr_pulse_q) begin
      ld_d = LD_ERROR;
    end else if (byte_valid_q) begin
      unique case (ld_q)
        LD_HDR0: begin
          cnt_lo_d = shift_q;
          ld_d     = LD_HDR1;
        end
        LD_HDR1: begin
          words_left_d = {shift_q, cnt_lo_q};
          word_idx_d   = '0;
          bidx_d       = '0;
          ld_d         = ({shift_q, cnt_lo_q} == 16'd0) ? LD_DONE : LD_WORD;
        end
        LD_WORD: begin
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              mem_write_d  = 1'b1;
              mem_data_d   = {shift_q, word_q};
              mem_addr_d   = BASE_ADDR + 32'({word_idx_q, 2'b00});
              words_left_d = words_left_q - 16'd1;
              word_idx_d   = word_idx_q + 16'd1;
              if (words_left_q == 16'd1) ld_d = LD_DONE;
            end
          endcase
        end
        default: ;
      endcase
    end
    done_d = (ld_d == LD_DONE);
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_data  = mem_data_q;
  assign mem.mem_write = mem_write_q;
  assign done          = done_q;
  assign frame_err     = frame_err_q;
  assign words_left    = words_left_q;

endmodule
